elevator_scan_ctrl: RTL and testbench
=====================================

# elevator_scan_ctrl

Parametrised multi-floor elevator controller that succeeds the single-request elevator state machine. It latches one call request per floor and serves them in SCAN order: it keeps its travel direction while requests lie ahead, then reverses. It models travel time and door dwell, and drives floor and status outputs to the display and top-level pins.

## Interface
Parameters:
- N_FLOORS, 8, number of floors (2..16); floors are numbered 0..N_FLOORS-1
- FLOOR_W, $clog2(N_FLOORS), width of the floor index
- TRAVEL_CYCLES, 10000000, clock cycles to move one floor (>=2)
- DOOR_CYCLES, 20000000, clock cycles the door stays open (>=2)

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_in  in  N_FLOORS  call buttons, one bit per floor; sampled every cycle, level or pulse
- current_floor  out  FLOOR_W  floor the car is at or last passed
- pending  out  N_FLOORS  latched, unserved requests
- moving_up  out  1  state is MOVE_UP
- moving_down  out  1  state is MOVE_DOWN
- door_open  out  1  state is DOOR_OPEN
- idle  out  1  state is IDLE

## Operation
- Reset values: state=IDLE, current_floor=0, pending=0, timer=0, dir=up. Outputs: idle=1, all other outputs 0.
- Request latching: pending[i] sets one cycle after req_in[i]=1.
  - Exception: a request for the floor whose door is opening or open is absorbed. The bit is not set.
  - pending[i] clears only when floor i is served.
- "above" means any pending bit > current_floor; "below" means any pending bit < current_floor.
- IDLE transitions, checked in this priority order:
  - pending[current_floor] set: go to DOOR_OPEN and clear the bit.
  - Requests exist in dir and the opposite side: move in dir.
  - Requests exist on one side only: move toward that side.
  - No requests: stay in IDLE.
  - dir updates to the chosen direction.
- MOVE_UP / MOVE_DOWN: the timer counts 0..TRAVEL_CYCLES-1. On the last count, current_floor steps by ±1 and the timer clears. At the new floor:
  - If it is pending: go to DOOR_OPEN and clear the bit.
  - Else if requests remain ahead: continue.
  - Else: go to IDLE.
- Floor bounds: the car never moves above N_FLOORS-1 or below 0. No wrap-around can occur, because movement only happens toward a pending floor.
- DOOR_OPEN: the timer counts 0..DOOR_CYCLES-1, then the state goes to IDLE.
  - A req_in for current_floor during DOOR_OPEN restarts the timer at 0 (door held open).
- Simultaneous events: requests for other floors latch normally in every state, on the same edge as any clear.

## Timing
- Request to first motion from IDLE: 2 cycles (latch edge, then decide edge).
- Request at the current floor from IDLE: door_open rises 2 edges after req_in.
- Travel: current_floor changes exactly TRAVEL_CYCLES cycles after entering a MOVE state, and every TRAVEL_CYCLES cycles after that.
- Door dwell: door_open stays high for exactly DOOR_CYCLES cycles (unless held open). It is followed by at least 1 cycle of idle=1.
- All outputs are registered or decoded directly from state; there are no combinational paths from req_in.
- Reset asserted mid-travel or mid-dwell: every output returns to its reset value immediately (asynchronously). The partial travel is discarded.

## Configuration
- ELEV_ESTOP_EN defined:
  - Adds port estop (in, 1).
  - While estop=1, the timer freezes, the state holds, and IDLE does not depart. Requests still latch.
  - Deasserting estop resumes the timer from its frozen count.
- ELEV_ESTOP_EN undefined: the estop port and its logic are absent.

## Structure
- Package elevator_pkg holds:
  - the state enum (IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN) and its 2-bit encoding
  - the dir encoding constants
  - the MAX_FLOORS=16 constant
- Sub-module elevator_req_reg holds the pending register with set/absorb/clear logic. It outputs the pending, any_above and any_below reductions relative to current_floor.

## Test plan
Bench settings: N_FLOORS=8, TRAVEL_CYCLES=4, DOOR_CYCLES=3.
- Reset: pulse rst_n low mid-simulation -> current_floor=0, pending=0, idle=1, other outputs 0, asynchronously.
- Single trip: at floor 0, pulse req_in[3] -> moving_up 2 cycles later; floor goes 1,2,3 at 4-cycle steps; door_open high 3 cycles; pending[3]=0; then idle.
- SCAN ordering: while moving to floor 5, request floors 2, 6 and 1 -> stops in order at 2, 5, 6, then reverses to 1; moving_down asserted after 6.
- Door hold: during DOOR_OPEN at floor 2, pulse req_in[2] -> timer restarts; door_open lasts 3 more cycles; pending[2] never sets.
- Reset mid-travel: assert rst_n=0 between floors 3 and 4 -> immediate reset values; the resumed trip starts from floor 0.
- ELEV_ESTOP_EN: raise estop for 10 cycles mid-travel -> current_floor and state frozen, a new request latches; the remaining travel count completes after release.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types and constants for the SCAN elevator controller.
// Covers the controller state encoding, the travel-direction encoding and the supported floor limit.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        MOVE_UP   = 2'b01,
        MOVE_DOWN = 2'b10,
        DOOR_OPEN = 2'b11
    } state_t;

    localparam logic DIR_DOWN = 1'b0;
    localparam logic DIR_UP   = 1'b1;

    localparam int MAX_FLOORS = 16;

endpackage

// File: rtl/elevator_req_reg.sv
// Per-floor call register: latches requests, absorbs calls for the floor whose door is open, and clears served floors.
// Also reports whether any call lies above or below the car's current floor.
module elevator_req_reg
    import elevator_pkg::*;
#(
    parameter int N_FLOORS = 8,
    parameter int FLOOR_W  = $clog2(N_FLOORS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_FLOORS-1:0] req,
    input  logic [FLOOR_W-1:0]  cur_floor,
    input  logic                door_open,
    input  logic                clr_en,
    input  logic [FLOOR_W-1:0]  clr_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                any_above,
    output logic                any_below
);

    logic [N_FLOORS-1:0] pending_nx;

    // Clear after set, so a floor being served this edge also swallows a coincident call.
    always_comb begin
        pending_nx = pending;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (req[i] && !(door_open && cur_floor == FLOOR_W'(i)))
                pending_nx[i] = 1'b1;
            if (clr_en && clr_floor == FLOOR_W'(i))
                pending_nx[i] = 1'b0;
        end
    end

    always_comb begin
        any_above = 1'b0;
        any_below = 1'b0;
        for (int i = 0; i < N_FLOORS; i++) begin
            if (pending[i] && FLOOR_W'(i) > cur_floor) any_above = 1'b1;
            if (pending[i] && FLOOR_W'(i) < cur_floor) any_below = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending <= '0;
        else        pending <= pending_nx;
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// Multi-floor elevator controller serving latched calls in SCAN order with travel and door-dwell timing.
// Optional macro ELEV_ESTOP_EN adds an estop input that freezes motion and timing while asserted.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS      = 8,
    parameter int FLOOR_W       = $clog2(N_FLOORS),
    parameter int TRAVEL_CYCLES = 10000000,
    parameter int DOOR_CYCLES   = 20000000
) (
    input  logic                clk,
    input  logic                rst_n,
`ifdef ELEV_ESTOP_EN
    input  logic                estop,
`endif
    input  logic [N_FLOORS-1:0] req_in,
    output logic [FLOOR_W-1:0]  current_floor,
    output logic [N_FLOORS-1:0] pending,
    output logic                moving_up,
    output logic                moving_down,
    output logic                door_open,
    output logic                idle
);

    localparam int TIMER_MAX = (TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES : DOOR_CYCLES;
    localparam int TIMER_W   = $clog2(TIMER_MAX);

    state_t               state, state_nx;
    logic [FLOOR_W-1:0]   floor_nx, step_floor, clr_floor;
    logic [TIMER_W-1:0]   timer, timer_nx;
    logic                 dir, dir_nx;
    logic                 clr_en, hold, any_above, any_below;

`ifdef ELEV_ESTOP_EN
    assign hold = estop;
`else
    assign hold = 1'b0;
`endif

    elevator_req_reg #(
        .N_FLOORS (N_FLOORS),
        .FLOOR_W  (FLOOR_W)
    ) u_req_reg (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req_in),
        .cur_floor (current_floor),
        .door_open (state == DOOR_OPEN),
        .clr_en    (clr_en),
        .clr_floor (clr_floor),
        .pending   (pending),
        .any_above (any_above),
        .any_below (any_below)
    );

    assign step_floor = (state == MOVE_UP) ? current_floor + FLOOR_W'(1)
                                           : current_floor - FLOOR_W'(1);

    // On arrival the target floor is not pending, so "ahead" relative to the old floor equals ahead of the new one.
    always_comb begin
        state_nx  = state;
        floor_nx  = current_floor;
        timer_nx  = timer;
        dir_nx    = dir;
        clr_en    = 1'b0;
        clr_floor = current_floor;
        if (!hold) begin
            case (state)
                IDLE: begin
                    timer_nx = '0;
                    if (pending[current_floor]) begin
                        state_nx = DOOR_OPEN;
                        clr_en   = 1'b1;
                    end else if (any_above && any_below) begin
                        state_nx = (dir == DIR_UP) ? MOVE_UP : MOVE_DOWN;
                    end else if (any_above) begin
                        state_nx = MOVE_UP;
                        dir_nx   = DIR_UP;
                    end else if (any_below) begin
                        state_nx = MOVE_DOWN;
                        dir_nx   = DIR_DOWN;
                    end
                end
                MOVE_UP, MOVE_DOWN: begin
                    if (timer == TIMER_W'(TRAVEL_CYCLES - 1)) begin
                        timer_nx  = '0;
                        floor_nx  = step_floor;
                        clr_floor = step_floor;
                        if (pending[step_floor]) begin
                            state_nx = DOOR_OPEN;
                            clr_en   = 1'b1;
                        end else if (!((state == MOVE_UP) ? any_above : any_below)) begin
                            state_nx = IDLE;
                        end
                    end else begin
                        timer_nx = timer + TIMER_W'(1);
                    end
                end
                DOOR_OPEN: begin
                    if (req_in[current_floor]) begin
                        timer_nx = '0;
                    end else if (timer == TIMER_W'(DOOR_CYCLES - 1)) begin
                        timer_nx = '0;
                        state_nx = IDLE;
                    end else begin
                        timer_nx = timer + TIMER_W'(1);
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            current_floor <= '0;
            timer         <= '0;
            dir           <= DIR_UP;
            idle          <= 1'b1;
            moving_up     <= 1'b0;
            moving_down   <= 1'b0;
            door_open     <= 1'b0;
        end else begin
            state         <= state_nx;
            current_floor <= floor_nx;
            timer         <= timer_nx;
            dir           <= dir_nx;
            idle          <= (state_nx == IDLE);
            moving_up     <= (state_nx == MOVE_UP);
            moving_down   <= (state_nx == MOVE_DOWN);
            door_open     <= (state_nx == DOOR_OPEN);
        end
    end

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed trips plus random calls, checked every cycle against a floor/call model.
// Define ELEV_ESTOP_EN to also exercise the emergency-stop freeze.
module tb_elevator_scan_ctrl;

    localparam int N  = 8;
    localparam int FW = 3;
    localparam int T  = 4;
    localparam int D  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          estop = 1'b0;
    logic [N-1:0]  req_in = '0;
    logic [FW-1:0] current_floor;
    logic [N-1:0]  pending;
    logic          moving_up, moving_down, door_open, idle;

    always #5 clk = ~clk;

    elevator_scan_ctrl #(
        .N_FLOORS      (N),
        .FLOOR_W       (FW),
        .TRAVEL_CYCLES (T),
        .DOOR_CYCLES   (D)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
`ifdef ELEV_ESTOP_EN
        .estop         (estop),
`endif
        .req_in        (req_in),
        .current_floor (current_floor),
        .pending       (pending),
        .moving_up     (moving_up),
        .moving_down   (moving_down),
        .door_open     (door_open),
        .idle          (idle)
    );

    typedef enum {M_REST, M_UP, M_DOWN, M_DOOR} mode_t;
    mode_t   m_mode;
    int      m_floor, m_count;
    bit      m_dir_up;
    bit [N-1:0] m_calls;

    int vectors = 0;
    int miscompares = 0;
    int stops[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_output();
        check("floor",       32'(current_floor), 32'(m_floor));
        check("pending",     32'(pending),       32'(m_calls));
        check("moving_up",   32'(moving_up),     32'(m_mode == M_UP));
        check("moving_down", 32'(moving_down),   32'(m_mode == M_DOWN));
        check("door_open",   32'(door_open),     32'(m_mode == M_DOOR));
        check("idle",        32'(idle),          32'(m_mode == M_REST));
    endtask

    task automatic model_reset();
        m_mode = M_REST; m_floor = 0; m_count = 0; m_dir_up = 1'b1; m_calls = '0;
    endtask

    function automatic bit calls_beyond(input int from, input bit upward);
        for (int i = 0; i < N; i++)
            if (m_calls[i] && (upward ? (i > from) : (i < from))) return 1'b1;
        return 1'b0;
    endfunction

    // One clock edge of the elevator's rules: calls latch, then the car decides, moves or dwells.
    task automatic model_step(input logic [N-1:0] r, input logic es);
        bit [N-1:0] nc;
        bit up_s, dn_s, go_up;
        nc = m_calls;
        for (int i = 0; i < N; i++)
            if (r[i] === 1'b1 && !(m_mode == M_DOOR && i == m_floor)) nc[i] = 1'b1;
        up_s = calls_beyond(m_floor, 1'b1);
        dn_s = calls_beyond(m_floor, 1'b0);
        if (es !== 1'b1) begin
            case (m_mode)
                M_REST: begin
                    if (m_calls[m_floor]) begin
                        m_mode = M_DOOR; m_count = 0; nc[m_floor] = 1'b0;
                    end else if (up_s || dn_s) begin
                        go_up = (up_s && dn_s) ? m_dir_up : up_s;
                        m_dir_up = go_up;
                        m_mode = go_up ? M_UP : M_DOWN;
                        m_count = 0;
                    end
                end
                M_UP, M_DOWN: begin
                    m_count++;
                    if (m_count == T) begin
                        m_count = 0;
                        m_floor += (m_mode == M_UP) ? 1 : -1;
                        if (m_calls[m_floor]) begin
                            m_mode = M_DOOR; nc[m_floor] = 1'b0;
                        end else if (!calls_beyond(m_floor, m_mode == M_UP)) begin
                            m_mode = M_REST;
                        end
                    end
                end
                M_DOOR: begin
                    if (r[m_floor] === 1'b1) m_count = 0;
                    else if (m_count + 1 == D) begin m_mode = M_REST; m_count = 0; end
                    else m_count++;
                end
                default: m_mode = M_REST;
            endcase
        end
        m_calls = nc;
    endtask

    task automatic apply_stimulus(input logic [N-1:0] r);
        @(negedge clk);
        check_output();
        req_in = r;
        @(posedge clk);
        model_step(r, estop);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        req_in = '0;
        #2 rst_n = 1'b0;
        #1 model_reset();
        check("rst_floor",   32'(current_floor), 32'd0);
        check("rst_pending", 32'(pending),       32'd0);
        check("rst_idle",    32'(idle),          32'd1);
        check("rst_up",      32'(moving_up),     32'd0);
        check("rst_down",    32'(moving_down),   32'd0);
        check("rst_door",    32'(door_open),     32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic run_until_floor(input int f, input int limit);
        int n = 0;
        while (current_floor !== FW'(f) && n < limit) begin
            apply_stimulus('0);
            n++;
        end
        check("reach_floor", 32'(current_floor), 32'(f));
    endtask

    task automatic run_until_door(input int limit);
        int n = 0;
        while (door_open !== 1'b1 && n < limit) begin
            apply_stimulus('0);
            n++;
        end
        check("reach_door", 32'(door_open), 32'd1);
    endtask

    task automatic run_until_quiet(input int limit);
        int n = 0;
        while ((idle !== 1'b1 || pending !== '0) && n < limit) begin
            apply_stimulus('0);
            n++;
        end
        check("reach_quiet", 32'({idle, pending}), 32'({1'b1, 8'h00}));
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [N-1:0] r;
        bit prev_door, saw_down;
        int n, hold_cycles;
        int exp_stops[4] = '{2, 5, 6, 1};

        model_reset();
        #17 rst_n = 1'b1;

        $display("[TB] single trip to floor 3");
        apply_stimulus(8'h08);
        apply_stimulus(8'h00);
        check("trip_depart_up", 32'(moving_up), 32'd1);
        check("trip_depart_floor", 32'(current_floor), 32'd0);
        for (int f = 1; f <= 3; f++) begin
            repeat (T) apply_stimulus(8'h00);
            check("trip_floor_step", 32'(current_floor), 32'(f));
        end
        check("trip_door", 32'(door_open), 32'd1);
        check("trip_cleared", 32'(pending[3]), 32'd0);
        repeat (D - 1) apply_stimulus(8'h00);
        check("trip_door_hold", 32'(door_open), 32'd1);
        apply_stimulus(8'h00);
        check("trip_idle", 32'(idle), 32'd1);

        $display("[TB] reset mid-travel");
        apply_stimulus(8'h80);
        repeat (3) apply_stimulus(8'h00);
        check("mid_travel_up", 32'(moving_up), 32'd1);
        do_reset();
        apply_stimulus(8'h02);
        apply_stimulus(8'h00);
        check("resume_from_0", 32'(current_floor), 32'd0);
        run_until_floor(1, 20);
        check("resume_door", 32'(door_open), 32'd1);
        run_until_quiet(20);

        $display("[TB] SCAN ordering");
        apply_stimulus(8'h20);
        apply_stimulus(8'h00);
        apply_stimulus(8'h46);
        prev_door = 1'b0;
        saw_down = 1'b0;
        n = 0;
        while ((stops.size() < 4 || idle !== 1'b1) && n < 300) begin
            apply_stimulus(8'h00);
            if (door_open === 1'b1 && !prev_door) stops.push_back(int'(current_floor));
            if (stops.size() == 3 && moving_down === 1'b1) saw_down = 1'b1;
            prev_door = (door_open === 1'b1);
            n++;
        end
        check("scan_stop_count", 32'(stops.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            check("scan_stop_floor", (i < stops.size()) ? 32'(stops[i]) : 32'hFFFF_FFFF, 32'(exp_stops[i]));
        check("scan_reverse", 32'(saw_down), 32'd1);

        $display("[TB] door hold at floor 2");
        apply_stimulus(8'h04);
        run_until_door(30);
        apply_stimulus(8'h00);
        apply_stimulus(8'h04);
        check("hold_absorb", 32'(pending[2]), 32'd0);
        hold_cycles = 0;
        while (door_open === 1'b1 && hold_cycles < 10) begin
            hold_cycles++;
            apply_stimulus(8'h00);
        end
        check("hold_cycles", 32'(hold_cycles), 32'(D));
        check("hold_then_idle", 32'(idle), 32'd1);

`ifdef ELEV_ESTOP_EN
        $display("[TB] emergency stop mid-travel");
        begin
            logic [FW-1:0] f0;
            apply_stimulus(8'h80);
            apply_stimulus(8'h00);
            apply_stimulus(8'h00);
            f0 = current_floor;
            estop = 1'b1;
            for (int i = 0; i < 10; i++) apply_stimulus(i == 3 ? 8'h01 : 8'h00);
            check("estop_floor", 32'(current_floor), 32'(f0));
            check("estop_state", 32'(moving_up), 32'd1);
            check("estop_latch", 32'(pending[0]), 32'd1);
            estop = 1'b0;
            run_until_quiet(200);
        end
`endif

        $display("[TB] random calls");
        for (int i = 0; i < 400; i++) begin
            r = '0;
            if ($urandom_range(0, 5) == 0) r[$urandom_range(0, N - 1)] = 1'b1;
            if ($urandom_range(0, 40) == 0) r = N'($urandom);
`ifdef ELEV_ESTOP_EN
            estop = ($urandom_range(0, 15) == 0);
`endif
            if (i == 200) do_reset();
            apply_stimulus(r);
        end
        estop = 1'b0;
        run_until_quiet(500);
        apply_stimulus(8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
